// File: rtl/hb_interp.sv
// Half-band 2x interpolator: each accepted 16-bit input produces an even-phase
// sample (7 symmetric tap pairs) followed by an odd-phase sample (center tap).
module hb_interp (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] x_in,
  input  logic        x_valid,
  output logic        x_ready,
  output logic [15:0] y_out,
  output logic        y_valid,
  input  logic        y_ready,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2
  } state_t;

  localparam logic signed [15:0] W_EVEN [7] = '{
    16'sd459, -16'sd484, 16'sd749, -16'sd1154, 16'sd1834, -16'sd3323, 16'sd10377
  };
  localparam logic signed [15:0] W_CENTER = 16'sd16383;

  state_t             state_q, state_d;
  logic signed [15:0] d_q [13];
  logic        [15:0] y_q, y_d;
  logic        [15:0] hold_q, hold_d;
  logic               yv_q, yv_d;

  logic               accept;
  logic signed [15:0] e [14];
  logic signed [16:0] pair;
  logic signed [33:0] acc_even, acc_odd;
  logic        [15:0] even_res, odd_res;

  // Floor divide by 2^14 (gain 2 on Q15 taps), then clamp to 16 bits.
  function automatic logic [15:0] scale(input logic signed [33:0] a);
    logic signed [33:0] sh;
    sh = a >>> 14;
    if (sh > 34'sd32767)       scale = 16'h7fff;
    else if (sh < -34'sd32768) scale = 16'h8000;
    else                       scale = sh[15:0];
  endfunction

  assign x_ready   = (state_q == IDLE) || ((state_q == ODD) && y_ready);
  assign accept    = x_valid && x_ready;
  assign y_out     = y_q;
  assign y_valid   = yv_q;
  assign state_dbg = state_q;

  // Filter taps see the line as it will be after the shift: x_in is newest.
  // The oldest tap e[13] is d[12]; nothing older is ever read.
  always_comb begin
    e[0] = x_in;
    for (int k = 1; k < 14; k++) e[k] = d_q[k-1];
  end

  always_comb begin
    acc_even = '0;
    pair     = '0;
    for (int k = 0; k < 7; k++) begin
      pair     = 17'(e[k]) + 17'(e[13-k]);
      acc_even = acc_even + 34'(pair) * 34'(W_EVEN[k]);
    end
    acc_odd  = 34'(e[6]) * 34'(W_CENTER);
    even_res = scale(acc_even);
    odd_res  = scale(acc_odd);
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    hold_d  = hold_q;
    yv_d    = yv_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          y_d     = even_res;
          hold_d  = odd_res;
          yv_d    = 1'b1;
          state_d = EVEN;
        end
      end
      EVEN: begin
        if (y_ready) begin
          y_d     = hold_q;
          state_d = ODD;
        end
      end
      ODD: begin
        if (y_ready) begin
          if (accept) begin
            y_d     = even_res;
            hold_d  = odd_res;
            state_d = EVEN;
          end else begin
            yv_d    = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        yv_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      y_q     <= '0;
      hold_q  <= '0;
      yv_q    <= 1'b0;
      for (int k = 0; k < 13; k++) d_q[k] <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      hold_q  <= hold_d;
      yv_q    <= yv_d;
      if (accept) begin
        d_q[0] <= x_in;
        for (int k = 1; k < 13; k++) d_q[k] <= d_q[k-1];
      end
    end
  end

endmodule

// File: tb/tb_hb_interp.sv
// Bench for hb_interp: directed stimulus with a scoreboard queue of expected
// output samples, popped by a monitor on every y_valid && y_ready transfer.
module tb_hb_interp;

  logic        clk;
  logic        reset_n;
  logic [15:0] x_in;
  logic        x_valid;
  logic        x_ready;
  logic [15:0] y_out;
  logic        y_valid;
  logic        y_ready;
  logic [1:0]  state_dbg;

  logic [15:0] exp_q[$];
  int          checks;
  int          failures;
  int          hist [13];
  time         last_acc_t;
  time         first_acc_t;

  int W_EVEN [7] = '{459, -484, 749, -1154, 1834, -3323, 10377};
  int IMP_E  [14] = '{459, -484, 749, -1154, 1834, -3323, 10377,
                      10377, -3323, 1834, -1154, 749, -484, 459};
  int IMP_O  [14] = '{0, 0, 0, 0, 0, 0, 16383, 0, 0, 0, 0, 0, 0, 0};

  hb_interp dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .x_in      (x_in),
    .x_valid   (x_valid),
    .x_ready   (x_ready),
    .y_out     (y_out),
    .y_valid   (y_valid),
    .y_ready   (y_ready),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sat_shift(input longint acc);
    longint s;
    s = acc >>> 14;
    if (s > 32767)  return 32767;
    if (s < -32768) return -32768;
    return int'(s);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 13; k++) hist[k] = 0;
    exp_q.delete();
  endtask

  // Driver: present x until accepted; then push expected pair and shift the model line.
  task automatic send(input int x, input bit use_k, input int ke, input int ko);
    bit     acc;
    int     n;
    int     e [14];
    longint a;
    acc = 1'b0;
    n = 0;
    x_in    = 16'(x);
    x_valid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = x_ready;
      @(posedge clk);
      #1;
      n++;
    end
    x_valid = 1'b0;
    if (!acc) begin
      chk("send_timeout", 0, 1);
      return;
    end
    last_acc_t = $time;
    e[0] = x;
    for (int k = 1; k < 14; k++) e[k] = hist[k-1];
    a = 0;
    for (int k = 0; k < 7; k++) a += longint'(W_EVEN[k]) * longint'(e[k] + e[13-k]);
    if (use_k) begin
      exp_q.push_back(16'(ke));
      exp_q.push_back(16'(ko));
    end else begin
      exp_q.push_back(16'(sat_shift(a)));
      exp_q.push_back(16'(sat_shift(longint'(16383) * longint'(e[6]))));
    end
    for (int k = 12; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = x;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    logic [15:0] exp_v;
    forever begin
      @(negedge clk);
      if (reset_n && y_valid && y_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", $signed(y_out), 99999);
        end else begin
          exp_v = exp_q.pop_front();
          chk("y_out", $signed(y_out), $signed(exp_v));
        end
      end
    end
  endtask

  task automatic run_impulse(input string tag);
    y_ready = 1'b1;
    for (int i = 0; i < 14; i++) send((i == 0) ? 16384 : 0, 1'b1, IMP_E[i], IMP_O[i]);
    drain();
    chk({tag, "_idle_valid"}, y_valid, 0);
    chk({tag, "_idle_state"}, state_dbg, 0);
  endtask

  initial begin
    int v;
    int k;
    bit pos;
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    x_in     = '0;
    x_valid  = 1'b0;
    y_ready  = 1'b1;
    clear_model();
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("reset_y_valid", y_valid, 0);
    chk("reset_y_out", y_out, 0);
    chk("reset_x_ready", x_ready, 1);
    chk("reset_state", state_dbg, 0);
    @(posedge clk);
    #1;

    run_impulse("impulse");

    // Idle gap: a lone input after the line returned to idle uses retained history.
    send(5000, 1'b0, 0, 0);
    drain();
    chk("gap_idle_valid", y_valid, 0);
    send(-7000, 1'b0, 0, 0);
    drain();

    // DC: 14 back-to-back inputs fill the line; two more give the steady pair.
    for (int i = 0; i < 16; i++) begin
      if (i < 13) send(1000, 1'b0, 0, 0);
      else        send(1000, 1'b1, 1032, 999);
      if (i == 0) first_acc_t = last_acc_t;
    end
    chk("dc_gapless_time", int'(last_acc_t - first_acc_t), 15 * 2 * 10);
    drain();

    // Saturation: signs of the samples follow (or oppose) the tap signs.
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 14; i++) begin
        k = 13 - i;
        pos = (k <= 6) ? (k % 2 == 0) : (k % 2 == 1);
        if (pass == 1) pos = !pos;
        v = pos ? 32767 : -32768;
        if (i < 13)        send(v, 1'b0, 0, 0);
        else if (pass == 0) send(v, 1'b1, 32767, 32765);
        else               send(v, 1'b1, -32768, -32766);
      end
    end
    drain();

    // Backpressure: stall in EVEN with a new input waiting.
    y_ready = 1'b0;
    send(1234, 1'b0, 0, 0);
    x_in    = 16'd777;
    x_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_y_valid", y_valid, 1);
      chk("stall_x_ready", x_ready, 0);
      chk("stall_y_out", $signed(y_out), $signed(exp_q[0]));
    end
    @(posedge clk);
    #1;
    y_ready = 1'b1;
    send(777, 1'b0, 0, 0);
    send(-300, 1'b0, 0, 0);
    drain();

    // Reset mid-pair: pending odd sample is dropped, history cleared.
    y_ready = 1'b0;
    send(2222, 1'b0, 0, 0);
    reset_n = 1'b0;
    #1;
    chk("midreset_y_valid", y_valid, 0);
    chk("midreset_y_out", y_out, 0);
    clear_model();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    run_impulse("impulse2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
